// File: rtl/rom_loader.sv
// Byte-stream to ROM word writer: packs bytes LE into 32-bit writes.
// Optional running checksum of written words: ROM_LOADER_CHECKSUM_EN.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module rom_loader #(
  parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = `BUS_DATA_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  rom_we_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic [DATA_WIDTH-1:0] rom_data_o,
  output logic                  hold_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  wcnt;
  logic [1:0]            bcnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  err;
  logic                  xfer;
  logic                  wr;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [LEN_WIDTH-1:0]  wcnt_inc;

  // Abort masks every output event of the current cycle.
  assign byte_ready_o = (state == S_COLLECT) & ~abort_i;
  assign xfer         = byte_ready_o & byte_valid_i;
  assign wr           = (state == S_WRITE) & ~abort_i;
  assign rom_we_o     = wr;
  assign rom_addr_o   = addr;
  assign rom_data_o   = wr ? asm_q : '0;
  assign hold_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE) & ~abort_i;
  assign err_o        = err;

  // Carry out of the address increment flags a wrap past the ROM top.
  assign addr_inc = {1'b0, addr} + (ADDR_WIDTH+1)'(4);
  assign wcnt_inc = wcnt + LEN_WIDTH'(1);

  // Load sequencing: state, address, word count and wrap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= '0;
      len_q <= '0;
      wcnt  <= '0;
      err   <= 1'b0;
    end else if (abort_i) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            addr  <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            len_q <= len_i;
            wcnt  <= '0;
            err   <= 1'b0;
            state <= (len_i == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (xfer && bcnt == 2'd3) state <= S_WRITE;
        end
        S_WRITE: begin
          addr <= addr_inc[ADDR_WIDTH-1:0];
          if (addr_inc[ADDR_WIDTH]) err <= 1'b1;
          wcnt  <= wcnt_inc;
          state <= (wcnt_inc == len_q) ? S_DONE : S_COLLECT;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Little-endian byte packing; partial words are dropped on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      asm_q <= '0;
    end else if (abort_i) begin
      bcnt  <= '0;
      asm_q <= '0;
    end else if (xfer) begin
      asm_q[{bcnt, 3'b000} +: 8] <= byte_data_i;
      bcnt <= bcnt + 2'd1;
    end else if (wr) begin
      asm_q <= '0;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  assign checksum_o = sum;

  // Running modulo-2^32 sum of every word written in this load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (!abort_i && state == S_IDLE && start_i) begin
      sum <= '0;
    end else if (wr) begin
      sum <= sum + asm_q[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a transaction-level model.
// Model predicts writes/done/ready from accepted bytes and control.
`timescale 1ns/1ps

module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  base_addr_i;
  logic [15:0] len_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        rom_we_o;
  logic [7:0]  rom_addr_o;
  logic [31:0] rom_data_o;
  logic        hold_o;
  logic        done_o;
  logic        err_o;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
  logic [31:0] last_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx[$];
  logic [39:0] wlog[$];

  rom_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .rom_we_o     (rom_we_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_o   (rom_data_o),
    .hold_o       (hold_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  // Model state: load in progress, pending write/done, packed word.
  logic        m_active, m_pw, m_pd, m_err;
  logic [7:0]  m_addr;
  logic [31:0] m_word, m_sum;
  int          m_n, m_len, m_words;
  logic        e_we, e_done, e_rdy;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_pw = 0; m_pd = 0; m_err = 0;
      m_addr = 0; m_word = 0; m_sum = 0;
      m_n = 0; m_len = 0; m_words = 0;
    end else begin
      e_we   = m_pw && !abort_i;
      e_done = m_pd && !abort_i;
      e_rdy  = m_active && !m_pw && !m_pd && !abort_i;
      chk("we", rom_we_o, e_we);
      chk("ready", byte_ready_o, e_rdy);
      chk("done", done_o, e_done);
      chk("hold", hold_o, m_active);
      chk("addr", rom_addr_o, m_addr);
      chk("data", rom_data_o, e_we ? m_word : 32'h0);
      chk("err", err_o, m_err);
`ifdef ROM_LOADER_CHECKSUM_EN
      if (e_done) chk("cksum", checksum_o, m_sum);
`endif
      if (rom_we_o) wlog.push_back({rom_addr_o, rom_data_o});
      if (abort_i) begin
        m_active = 0; m_pw = 0; m_pd = 0; m_n = 0;
      end else if (!m_active) begin
        if (start_i) begin
          m_active = 1;
          m_addr = base_addr_i & 8'hFC;
          m_len = int'(len_i);
          m_words = 0; m_err = 0; m_sum = 0; m_n = 0;
          m_pd = (len_i == 0);
        end
      end else if (m_pd) begin
        m_pd = 0;
        m_active = 0;
      end else if (m_pw) begin
        m_pw = 0;
        m_sum = m_sum + m_word;
        m_words++;
        if (int'(m_addr) + 4 > 255) m_err = 1;
        m_addr = m_addr + 8'd4;
        if (m_words == m_len) m_pd = 1;
      end else if (byte_valid_i) begin
        if (m_n == 0) m_word = 0;
        m_word[8*m_n +: 8] = byte_data_i;
        m_n++;
        if (m_n == 4) begin
          m_n = 0;
          m_pw = 1;
        end
      end
    end
  end

  task automatic start_load(input logic [7:0] b, input logic [15:0] l);
    start_i = 1; base_addr_i = b; len_i = l;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic send_q();
    for (int i = 0; i < tx.size(); i++) begin
      int t = 0;
      byte_data_i  = tx[i];
      byte_valid_i = 1;
      forever begin
        @(negedge clk);
        if (byte_ready_o) break;
        t++;
        if (t > 50) begin
          timeout("byte_handshake");
          break;
        end
      end
      @(posedge clk); #1;
    end
    byte_valid_i = 0;
    tx.delete();
  endtask

  task automatic wait_done();
    int t = 0;
    forever begin
      @(negedge clk);
      if (done_o) break;
      t++;
      if (t > 100) begin
        timeout("wait_done");
        break;
      end
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    last_sum = checksum_o;
`endif
    @(posedge clk); #1;
  endtask

  task automatic pin_wr(input int idx, input logic [7:0] a,
                        input logic [31:0] d);
    if (idx >= wlog.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL pin_wr: write %0d missing, got %0d writes", idx,
               wlog.size());
    end else begin
      chk("pin_addr", wlog[idx][39:32], a);
      chk("pin_data", wlog[idx][31:0], d);
    end
  endtask

  int base_n;

  initial begin
    rst = 1; start_i = 0; abort_i = 0; base_addr_i = 0; len_i = 0;
    byte_valid_i = 0; byte_data_i = 0;
    #12;
    chk("rst_hold", hold_o, 0);
    chk("rst_we", rom_we_o, 0);
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_addr", rom_addr_o, 0);
    chk("rst_data", rom_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // 1: two words, write latency after 4th byte
    base_n = wlog.size();
    start_load(8'h10, 16'd2);
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_q();
    @(negedge clk);
    chk("lat_we", rom_we_o, 1);
    chk("lat_ready", byte_ready_o, 0);
    @(posedge clk); #1;
    tx = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_q();
    wait_done();
    pin_wr(base_n + 0, 8'h10, 32'h44332211);
    pin_wr(base_n + 1, 8'h14, 32'h88776655);
    @(negedge clk);
    chk("t1_hold_after", hold_o, 0);
    @(posedge clk); #1;

    // 2: zero length
    base_n = wlog.size();
    start_load(8'h40, 16'd0);
    @(negedge clk);
    chk("t2_done", done_o, 1);
    chk("t2_hold", hold_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_done_gone", done_o, 0);
    chk("t2_hold_gone", hold_o, 0);
    chk("t2_no_write", wlog.size(), base_n);
    @(posedge clk); #1;

    // 3: abort mid-word, then a clean one-word load
    base_n = wlog.size();
    start_load(8'h30, 16'd2);
    tx = '{8'h01, 8'h02};
    send_q();
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    @(negedge clk);
    chk("t3_idle", hold_o, 0);
    chk("t3_no_write", wlog.size(), base_n);
    @(posedge clk); #1;
    start_load(8'h20, 16'd1);
    tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_q();
    wait_done();
    pin_wr(base_n, 8'h20, 32'hDDCCBBAA);

    // abort in the write cycle, and start+abort together in idle
    base_n = wlog.size();
    start_load(8'h50, 16'd1);
    tx = '{8'h9A, 8'h9B, 8'h9C, 8'h9D};
    send_q();
    abort_i = 1;
    @(negedge clk);
    chk("abw_we", rom_we_o, 0);
    @(posedge clk); #1;
    abort_i = 0;
    @(negedge clk);
    chk("abw_idle", hold_o, 0);
    chk("abw_no_write", wlog.size(), base_n);
    @(posedge clk); #1;
    start_i = 1; abort_i = 1; len_i = 16'd1;
    @(posedge clk); #1;
    start_i = 0; abort_i = 0;
    @(negedge clk);
    chk("sa_idle", hold_o, 0);
    @(posedge clk); #1;

    // 4: address wrap on 8-bit ROM
    base_n = wlog.size();
    start_load(8'hFE, 16'd2);
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_q();
    wait_done();
    pin_wr(base_n + 0, 8'hFC, 32'h04030201);
    pin_wr(base_n + 1, 8'h00, 32'h08070605);
    repeat (3) begin
      @(negedge clk);
      chk("t4_err_sticky", err_o, 1);
    end
    @(posedge clk); #1;
    start_load(8'h00, 16'd0);
    @(negedge clk);
    chk("t4_err_clear", err_o, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // 5: continuous valid, start pulse mid-load ignored
    base_n = wlog.size();
    start_load(8'h80, 16'd2);
    tx = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    fork
      send_q();
      begin
        repeat (6) @(posedge clk);
        #1;
        start_i = 1; base_addr_i = 8'h90; len_i = 16'd5;
        @(posedge clk); #1;
        start_i = 0;
      end
    join
    wait_done();
    chk("t5_nwrites", wlog.size() - base_n, 2);
    pin_wr(base_n + 0, 8'h80, 32'hC3C2C1C0);
    pin_wr(base_n + 1, 8'h84, 32'hC7C6C5C4);

    // asynchronous reset in the middle of a load
    start_load(8'h60, 16'd1);
    tx = '{8'h71, 8'h72};
    send_q();
    #2 rst = 1;
    #1;
    chk("ar_hold", hold_o, 0);
    chk("ar_ready", byte_ready_o, 0);
    chk("ar_addr", rom_addr_o, 0);
    chk("ar_we", rom_we_o, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    base_n = wlog.size();
    start_load(8'h64, 16'd1);
    tx = '{8'h81, 8'h82, 8'h83, 8'h84};
    send_q();
    wait_done();
    pin_wr(base_n, 8'h64, 32'h84838281);

`ifdef ROM_LOADER_CHECKSUM_EN
    // 6: checksum wraps modulo 2^32
    start_load(8'h00, 16'd2);
    tx = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_q();
    wait_done();
    chk("t6_cksum", last_sum, 32'h00000001);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
